clock_time_cnt: RTL and testbench

- Timekeeping core of the digital clock, directly upstream of the binary-to-BCD converter.
- Keeps hours, minutes and seconds as binary counters driven by a prescaled 1 Hz tick, and supports manual time setting.
- Sends each field to the converter one byte at a time as bin_out with a one-cycle dout_vld pulse.
- Consecutive pulses are spaced so the converter's 8-cycle serial conversion always completes before the next byte arrives.

---
 rtl/clock_pkg.sv | 30 +++
 rtl/tick_gen.sv | 29 ++
 rtl/clock_time_cnt.sv | 135 +++++++++++++
 tb/tb_clock_time_cnt.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared field, limit and FSM encodings for the clock timekeeping core.
// Pure declarations; no latency or flow control of its own.
package clock_pkg;

  typedef enum logic [1:0] {
    FLD_SEC  = 2'd0,
    FLD_MIN  = 2'd1,
    FLD_HOUR = 2'd2,
    FLD_NONE = 2'd3
  } field_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  function automatic logic [5:0] inc_wrap60(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_hour(input logic [4:0] v);
    return (v == HOUR_MAX) ? 5'd0 : v + 5'd1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a registered one-cycle sec_tick every CLK_FREQ cycles.
// Tick lands one cycle after the terminal count; hold parks the count at 0 and suppresses ticks.
module tick_gen #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic sec_tick
);

  localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || hold) begin
      cnt      <= '0;
      sec_tick <= 1'b0;
    end else if (cnt == CW'(CLK_FREQ - 1)) begin
      cnt      <= '0;
      sec_tick <= 1'b1;
    end else begin
      cnt      <= cnt + CW'(1);
      sec_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_time_cnt.sv
// Hours/minutes/seconds counters with manual set, serialised to the BCD converter as sec, min, hour.
// First byte 2 cycles after the trigger, then one every CONV_GAP cycles; triggers during a dispatch queue one more.
module clock_time_cnt
  import clock_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int CONV_GAP = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic       set_inc,
  output logic [7:0] bin_out,
  output logic       dout_vld,
  output logic [1:0] field_id,
  output logic       sec_tick,
  output logic       busy
);

  localparam int GW = $clog2(CONV_GAP);

  logic [5:0]    sec;
  logic [5:0]    min;
  logic [4:0]    hour;
  logic          set_en_q;
  logic          pending;
  logic          take;
  logic          set_hit;
  logic          trigger;
  field_e        sel;
  state_e        state, state_n;
  logic [1:0]    idx, idx_n;
  logic [GW-1:0] gcnt, gcnt_n;

  tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .hold     (set_en),
    .sec_tick (sec_tick)
  );

  assign sel     = field_e'(set_sel);
  assign set_hit = set_en && set_inc && (sel != FLD_NONE);
  assign trigger = sec_tick || set_hit || (set_en_q && !set_en);

  // Set mode takes priority so a stale tick in the first set cycle cannot move the time.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec  <= '0;
      min  <= '0;
      hour <= '0;
    end else if (set_en) begin
      if (set_hit) begin
        case (sel)
          FLD_SEC:  sec  <= inc_wrap60(sec, SEC_MAX);
          FLD_MIN:  min  <= inc_wrap60(min, MIN_MAX);
          FLD_HOUR: hour <= inc_hour(hour);
          default:  ;
        endcase
      end
    end else if (sec_tick) begin
      sec <= inc_wrap60(sec, SEC_MAX);
      if (sec == SEC_MAX) begin
        min <= inc_wrap60(min, MIN_MAX);
        if (min == MIN_MAX) hour <= inc_hour(hour);
      end
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    gcnt_n  = gcnt;
    take    = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          state_n = EMIT;
          idx_n   = 2'd0;
          take    = 1'b1;
        end
      end
      EMIT: begin
        state_n = GAP;
        gcnt_n  = '0;
      end
      GAP: begin
        if (gcnt == GW'(CONV_GAP - 2)) begin
          if (idx < 2'd2) begin
            idx_n   = idx + 2'd1;
            state_n = EMIT;
          end else begin
            state_n = IDLE;
          end
        end else begin
          gcnt_n = gcnt + GW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // bin_out is captured on entry to EMIT so it holds steady until the next byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      gcnt     <= '0;
      pending  <= 1'b1;
      set_en_q <= 1'b0;
      bin_out  <= '0;
      field_id <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      gcnt     <= gcnt_n;
      set_en_q <= set_en;
      if (trigger)   pending <= 1'b1;
      else if (take) pending <= 1'b0;
      if (state_n == EMIT) begin
        field_id <= idx_n;
        case (field_e'(idx_n))
          FLD_SEC:  bin_out <= {2'b00, sec};
          FLD_MIN:  bin_out <= {2'b00, min};
          default:  bin_out <= {3'b000, hour};
        endcase
      end
    end
  end

  assign dout_vld = (state == EMIT);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_clock_time_cnt.sv
// Directed bench for clock_time_cnt: reset dispatch, free run, set mode, rollover,
// mid-dispatch trigger and mid-dispatch reset, all against hand-computed values.
module tb_clock_time_cnt;

  localparam int CLK_FREQ = 40;
  localparam int CONV_GAP = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_en = 1'b0;
  logic [1:0] set_sel = 2'd3;
  logic       set_inc = 1'b0;
  logic [7:0] bin_out;
  logic       dout_vld;
  logic [1:0] field_id;
  logic       sec_tick;
  logic       busy;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int ticks_seen = 0;

  clock_time_cnt #(.CLK_FREQ(CLK_FREQ), .CONV_GAP(CONV_GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .set_sel  (set_sel),
    .set_inc  (set_inc),
    .bin_out  (bin_out),
    .dout_vld (dout_vld),
    .field_id (field_id),
    .sec_tick (sec_tick),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst && sec_tick) ticks_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic take_vld(input string tag, input logic [1:0] fld, input logic [7:0] val,
                          input int budget, output int at);
    int n;
    n = 0;
    while (!dout_vld && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " vld seen"}, 32'(dout_vld), 32'd1);
    at = cyc;
    check({tag, " field"}, 32'(field_id), 32'(fld));
    check({tag, " value"}, 32'(bin_out), 32'(val));
    @(negedge clk);
    check({tag, " one-cycle"}, 32'(dout_vld), 32'd0);
    check({tag, " hold"}, 32'(bin_out), 32'(val));
  endtask

  task automatic expect_dispatch(input string tag, input logic [7:0] s, input logic [7:0] m,
                                 input logic [7:0] h, input int budget, input bit from_tick);
    int t0, a0, a1, a2, n;
    t0 = 0;
    if (from_tick) begin
      n = 0;
      while (!sec_tick && n < budget) begin
        @(negedge clk);
        n++;
      end
      check({tag, " tick seen"}, 32'(sec_tick), 32'd1);
      t0 = cyc;
      @(negedge clk);
    end
    take_vld({tag, " sec"}, 2'd0, s, budget, a0);
    if (from_tick) check({tag, " tick-to-vld"}, 32'(a0 - t0), 32'd2);
    take_vld({tag, " min"}, 2'd1, m, CONV_GAP + 2, a1);
    check({tag, " sec-min gap"}, 32'(a1 - a0), 32'(CONV_GAP));
    take_vld({tag, " hour"}, 2'd2, h, CONV_GAP + 2, a2);
    check({tag, " min-hour gap"}, 32'(a2 - a1), 32'(CONV_GAP));
    repeat (CONV_GAP - 1) @(negedge clk);
    check({tag, " busy low"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n, q;
    n = 0;
    q = 0;
    while (q < 2 && n < budget) begin
      @(negedge clk);
      n++;
      q = busy ? 0 : q + 1;
    end
    check({tag, " idle"}, 32'(q >= 2), 32'd1);
  endtask

  task automatic pulse_inc(input logic [1:0] sel, input int cnt);
    set_sel = sel;
    repeat (cnt) begin
      set_inc = 1'b1;
      @(negedge clk);
      set_inc = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, ts, extra, t0, a0, a1, a2, a3, a4, a5;

    assert (CLK_FREQ >= 3 * CONV_GAP + 4)
      else $fatal(1, "FAIL param: CLK_FREQ %0d below %0d", CLK_FREQ, 3 * CONV_GAP + 4);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst bin_out", 32'(bin_out), 32'd0);
    check("rst dout_vld", 32'(dout_vld), 32'd0);
    check("rst field_id", 32'(field_id), 32'd0);
    check("rst sec_tick", 32'(sec_tick), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    rst = 1'b0;

    expect_dispatch("reset", 8'd0, 8'd0, 8'd0, 5, 1'b0);

    // Free run: ticks 1..74, then the 75th is checked end to end
    for (int k = 0; k < 74; k++) begin
      n = 0;
      while (!sec_tick && n < CLK_FREQ + 5) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
    end
    check("74 ticks", 32'(ticks_seen), 32'd74);
    expect_dispatch("tick75", 8'd15, 8'd1, 8'd0, CLK_FREQ + 5, 1'b1);

    // Hour set by 25 increments: wraps to 1, no carry, prescaler frozen
    set_en = 1'b1;
    ts = ticks_seen;
    pulse_inc(2'd2, 25);
    wait_idle("set hour", 300);
    check("set hour frozen", 32'(ticks_seen - ts), 32'd0);
    set_en = 1'b0;
    expect_dispatch("set hour", 8'd15, 8'd1, 8'd1, 10, 1'b0);

    // Preload 23:59:59 then roll over on the next tick
    set_en = 1'b1;
    ts = ticks_seen;
    pulse_inc(2'd0, 44);
    pulse_inc(2'd1, 58);
    pulse_inc(2'd2, 22);
    pulse_inc(2'd3, 3);
    wait_idle("preload", 300);
    check("preload frozen", 32'(ticks_seen - ts), 32'd0);
    set_en = 1'b0;
    expect_dispatch("preload", 8'd59, 8'd59, 8'd23, 10, 1'b0);
    expect_dispatch("rollover", 8'd0, 8'd0, 8'd0, CLK_FREQ + 5, 1'b1);

    // set_inc arriving 3 cycles into a tick dispatch
    n = 0;
    while (!sec_tick && n < CLK_FREQ + 5) begin
      @(negedge clk);
      n++;
    end
    check("mid tick seen", 32'(sec_tick), 32'd1);
    t0 = cyc;
    @(negedge clk);
    take_vld("mid sec", 2'd0, 8'd1, 4, a0);
    check("mid tick-to-vld", 32'(a0 - t0), 32'd2);
    set_en  = 1'b1;
    set_sel = 2'd0;
    @(negedge clk);
    @(negedge clk);
    set_inc = 1'b1;
    @(negedge clk);
    set_inc = 1'b0;
    take_vld("mid min", 2'd1, 8'd0, CONV_GAP + 2, a1);
    check("mid sec-min gap", 32'(a1 - a0), 32'(CONV_GAP));
    take_vld("mid hour", 2'd2, 8'd0, CONV_GAP + 2, a2);
    repeat (CONV_GAP - 1) @(negedge clk);
    check("mid busy low", 32'(busy), 32'd0);
    take_vld("redo sec", 2'd0, 8'd2, 3, a3);
    check("redo start", 32'(a3 - a2), 32'(CONV_GAP + 1));
    take_vld("redo min", 2'd1, 8'd0, CONV_GAP + 2, a4);
    check("redo sec-min gap", 32'(a4 - a3), 32'(CONV_GAP));
    take_vld("redo hour", 2'd2, 8'd0, CONV_GAP + 2, a5);
    check("redo min-hour gap", 32'(a5 - a4), 32'(CONV_GAP));
    repeat (CONV_GAP - 1) @(negedge clk);
    check("redo busy low", 32'(busy), 32'd0);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (dout_vld) extra++;
    end
    check("redo no extra", 32'(extra), 32'd0);
    set_en = 1'b0;
    expect_dispatch("release", 8'd2, 8'd0, 8'd0, 10, 1'b0);

    // Reset in the gap after the min byte: no hour byte, outputs cleared
    take_vld("abort sec", 2'd0, 8'd3, CLK_FREQ + 5, a0);
    take_vld("abort min", 2'd1, 8'd0, CONV_GAP + 2, a1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort bin_out", 32'(bin_out), 32'd0);
    check("abort dout_vld", 32'(dout_vld), 32'd0);
    check("abort field_id", 32'(field_id), 32'd0);
    check("abort sec_tick", 32'(sec_tick), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (dout_vld) extra++;
    end
    check("abort quiet", 32'(extra), 32'd0);
    rst = 1'b0;
    expect_dispatch("post rst", 8'd0, 8'd0, 8'd0, 5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
